// File: rtl/sr_cmd_gen_if.sv
// Button and latch-command signals of the SR latch command generator.
// Exposes one modport for the driving side and one for the generator.
interface sr_cmd_gen_if;
  logic btn_set;
  logic btn_reset;
  logic s;
  logic r;
  logic en;
  logic busy;
  logic last_cmd;
  logic conflict;

  modport master (
    output btn_set, btn_reset,
    input  s, r, en, busy, last_cmd, conflict
  );

  modport slave (
    input  btn_set, btn_reset,
    output s, r, en, busy, last_cmd, conflict
  );
endinterface

// File: rtl/sr_cmd_gen.sv
// Debounced pushbutton front end that issues fixed-width active-low set/reset
// pulses to a NAND SR latch, never driving s and r low together.
module sr_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int CNT_W           = 8
) (
  input  logic           clk,
  input  logic           rst,
  sr_cmd_gen_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE_SET = 2'd1,
    PULSE_RST = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PL_LAST = CNT_W'(PULSE_CYCLES - 1);

  // Index 0 is the set button, index 1 the reset button.
  logic [1:0]       raw_s;
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       stable_r;
  logic [1:0]       stable_d_r;
  logic [CNT_W-1:0] db_cnt_r [2];
  logic [1:0]       req_s;
  logic [1:0]       want_s;
  logic [1:0]       pend_r;

  state_t           state_r;
  logic [CNT_W-1:0] pcnt_r;
  logic             s_r;
  logic             r_r;
  logic             en_r;
  logic             busy_r;
  logic             last_cmd_r;
  logic             conflict_r;

  assign raw_s  = {bus.btn_reset, bus.btn_set};
  assign req_s  = stable_r & ~stable_d_r;
  assign want_s = req_s | pend_r;

  // Two-flop synchronizers and per-button debounce counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r    <= 2'b00;
      sync2_r    <= 2'b00;
      stable_r   <= 2'b00;
      stable_d_r <= 2'b00;
      db_cnt_r[0] <= '0;
      db_cnt_r[1] <= '0;
    end else begin
      sync1_r    <= raw_s;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          stable_r[i] <= sync2_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Command FSM; s and r are only ever lowered from IDLE, one at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      pcnt_r     <= '0;
      pend_r     <= 2'b00;
      s_r        <= 1'b1;
      r_r        <= 1'b1;
      en_r       <= 1'b0;
      busy_r     <= 1'b0;
      last_cmd_r <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      conflict_r <= 1'b0;
      case (state_r)
        IDLE: begin
          pend_r <= 2'b00;
          pcnt_r <= '0;
          if (&want_s) begin
            conflict_r <= 1'b1;
          end else if (want_s[0]) begin
            state_r    <= PULSE_SET;
            s_r        <= 1'b0;
            en_r       <= 1'b1;
            busy_r     <= 1'b1;
            last_cmd_r <= 1'b1;
          end else if (want_s[1]) begin
            state_r    <= PULSE_RST;
            r_r        <= 1'b0;
            en_r       <= 1'b1;
            busy_r     <= 1'b1;
            last_cmd_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        PULSE_SET, PULSE_RST: begin
          pend_r <= pend_r | req_s;
          if (pcnt_r == PL_LAST) begin
            state_r <= GAP;
            s_r     <= 1'b1;
            r_r     <= 1'b1;
          end else begin
            pcnt_r <= pcnt_r + CNT_W'(1);
          end
        end
        GAP: begin
          pend_r  <= pend_r | req_s;
          state_r <= IDLE;
          en_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          pend_r  <= 2'b00;
          s_r     <= 1'b1;
          r_r     <= 1'b1;
          en_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s        = s_r;
  assign bus.r        = r_r;
  assign bus.en       = en_r;
  assign bus.busy     = busy_r;
  assign bus.last_cmd = last_cmd_r;
  assign bus.conflict = conflict_r;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen: vector table, directed corner sequences
// and random bouncy buttons compared every cycle against a countdown model.
module tb_sr_cmd_gen;
  localparam int DEB = 4;
  localparam int PUL = 2;
  localparam int HL  = DEB + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sr_cmd_gen_if bus_if();

  sr_cmd_gen #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: raw history window, stable levels, countdown of busy cycles
  bit hist [2][HL];
  bit stab [2];
  bit stab_prev [2];
  int m_left;
  bit m_cmd_set;
  bit pend [2];
  bit m_last;
  bit m_conf;

  // observation statistics
  int cyc, s_low, r_low, conf_cnt, en_cnt, first_s_low, first_r_low;
  int s_run, r_run;

  typedef struct {
    logic bs;
    logic br;
    int   hold;
    int   exp_slow;
    int   exp_rlow;
    int   exp_conf;
    int   exp_last;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < HL; j++) hist[i][j] = 1'b0;
      stab[i] = 1'b0; stab_prev[i] = 1'b0; pend[i] = 1'b0;
    end
    m_left = 0; m_cmd_set = 1'b0; m_last = 1'b0; m_conf = 1'b0;
  endtask

  task automatic model_step(input bit bs, input bit br);
    bit raw [2];
    bit req [2];
    bit all_diff;
    raw[0] = bs; raw[1] = br;
    for (int i = 0; i < 2; i++) req[i] = stab[i] & ~stab_prev[i];
    // a level is accepted once the last DEB synchronized samples all disagree
    for (int i = 0; i < 2; i++) begin
      for (int j = HL - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = raw[i];
      all_diff = 1'b1;
      for (int j = 2; j < HL; j++) if (hist[i][j] == stab[i]) all_diff = 1'b0;
      stab_prev[i] = stab[i];
      if (all_diff) stab[i] = ~stab[i];
    end
    m_conf = 1'b0;
    if (m_left == 0) begin
      bit ws, wr;
      ws = req[0] | pend[0];
      wr = req[1] | pend[1];
      pend[0] = 1'b0; pend[1] = 1'b0;
      if (ws && wr) m_conf = 1'b1;
      else if (ws) begin m_left = PUL + 1; m_cmd_set = 1'b1; m_last = 1'b1; end
      else if (wr) begin m_left = PUL + 1; m_cmd_set = 1'b0; m_last = 1'b0; end
    end else begin
      pend[0] = pend[0] | req[0];
      pend[1] = pend[1] | req[1];
      m_left--;
    end
  endtask

  function automatic logic [5:0] model_out();
    logic es, er, eb;
    eb = (m_left > 0);
    es = !((m_left > 1) && m_cmd_set);
    er = !((m_left > 1) && !m_cmd_set);
    return {es, er, eb, eb, m_last, m_conf};
  endfunction

  task automatic clear_stats();
    cyc = 0; s_low = 0; r_low = 0; conf_cnt = 0; en_cnt = 0;
    first_s_low = 0; first_r_low = 0;
  endtask

  task automatic check_cycle();
    logic [5:0] got;
    got = {bus_if.s, bus_if.r, bus_if.en, bus_if.busy, bus_if.last_cmd, bus_if.conflict};
    cyc++;
    chk("outputs{s,r,en,busy,last,conf}", int'(got), int'(model_out()));
    chk("s_r_not_both_low", int'(bus_if.s | bus_if.r), 1);
    if (!bus_if.s) begin
      s_low++; s_run++;
      if (first_s_low == 0) first_s_low = cyc;
    end else if (s_run > 0) begin
      chk("s_pulse_width", s_run, PUL); s_run = 0;
    end
    if (!bus_if.r) begin
      r_low++; r_run++;
      if (first_r_low == 0) first_r_low = cyc;
    end else if (r_run > 0) begin
      chk("r_pulse_width", r_run, PUL); r_run = 0;
    end
    conf_cnt += int'(bus_if.conflict);
    en_cnt   += int'(bus_if.en);
  endtask

  task automatic cycle(input logic bs, input logic br);
    bus_if.btn_set   = bs;
    bus_if.btn_reset = br;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(bs, br);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  initial begin
    int hs, hr;
    logic ls, lr;
    vecs[0] = '{1'b1, 1'b0, 20, 2, 0, 0, 1};
    vecs[1] = '{1'b0, 1'b1, 20, 0, 2, 0, 0};
    vecs[2] = '{1'b1, 1'b1, 20, 0, 0, 1, 0};
    vecs[3] = '{1'b1, 1'b0, DEB - 1, 0, 0, 0, 0};
    vecs[4] = '{1'b1, 1'b0, DEB, 2, 0, 0, 1};
    vecs[5] = '{1'b0, 1'b1, DEB, 0, 2, 0, 0};

    s_run = 0; r_run = 0;
    model_reset();
    bus_if.btn_set = 1'b0; bus_if.btn_reset = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(3);

    // vector table: press, hold, release, observe
    for (int v = 0; v < 6; v++) begin
      clear_stats();
      for (int c = 0; c < vecs[v].hold; c++) cycle(vecs[v].bs, vecs[v].br);
      idle(20);
      chk($sformatf("vec%0d_s_low", v), s_low, vecs[v].exp_slow);
      chk($sformatf("vec%0d_r_low", v), r_low, vecs[v].exp_rlow);
      chk($sformatf("vec%0d_conflicts", v), conf_cnt, vecs[v].exp_conf);
      chk($sformatf("vec%0d_last_cmd", v), int'(bus_if.last_cmd), vecs[v].exp_last);
      if (vecs[v].exp_conf != 0) chk($sformatf("vec%0d_en_cycles", v), en_cnt, 0);
    end

    // clean press latency and pulse shape
    clear_stats();
    for (int c = 0; c < 20; c++) cycle(1'b1, 1'b0);
    idle(10);
    chk("set_latency", first_s_low, DEB + 3);
    chk("set_en_cycles", en_cnt, PUL + 1);
    chk("set_r_low", r_low, 0);

    // bounce rejection then one clean press
    clear_stats();
    for (int c = 0; c < 2; c++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0);
    for (int c = 0; c < 2; c++) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    idle(15);
    chk("bounce_s_low", s_low, 0);
    chk("bounce_en_cycles", en_cnt, 0);
    clear_stats();
    for (int c = 0; c < 12; c++) cycle(1'b1, 1'b0);
    idle(15);
    chk("after_bounce_s_low", s_low, PUL);

    // reset pressed during the set pulse: queued behind it
    clear_stats();
    for (int c = 0; c < 2; c++) cycle(1'b1, 1'b0);
    for (int c = 0; c < 25; c++) cycle(1'b1, 1'b1);
    idle(15);
    chk("pending_r_first_low", first_r_low, 11);
    chk("pending_s_low", s_low, PUL);
    chk("pending_r_low", r_low, PUL);
    chk("pending_last_cmd", int'(bus_if.last_cmd), 0);

    // reset pressed two cycles after the s pulse starts
    clear_stats();
    for (int c = 0; c < 8; c++) cycle(1'b1, 1'b0);
    for (int c = 0; c < 20; c++) cycle(1'b1, 1'b1);
    idle(15);
    chk("late_r_first_low", first_r_low, 15);
    chk("late_last_cmd", int'(bus_if.last_cmd), 0);

    // async reset in the middle of a set pulse
    clear_stats();
    for (int c = 0; c < DEB + 3; c++) cycle(1'b1, 1'b0);
    chk("pre_reset_s_low", int'(bus_if.s), 0);
    rst = 1'b1;
    bus_if.btn_set = 1'b0;
    #1;
    chk("async_reset_outs", int'({bus_if.s, bus_if.r, bus_if.en, bus_if.busy,
                                  bus_if.last_cmd, bus_if.conflict}), 6'b110000);
    model_reset();
    s_run = 0; r_run = 0;
    idle(3);
    rst = 1'b0;
    clear_stats();
    idle(15);
    chk("post_reset_en_cycles", en_cnt, 0);

    // random bouncy buttons
    hs = 0; hr = 0; ls = 1'b0; lr = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (hs == 0) begin ls = logic'($urandom_range(0, 1)); hs = $urandom_range(1, 12); end
      if (hr == 0) begin lr = logic'($urandom_range(0, 1)); hr = $urandom_range(1, 12); end
      if ($urandom_range(0, 15) == 0) begin lr = ls; hr = hs; end
      cycle(ls, lr);
      hs--; hr--;
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
